serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_rx.sv | 144 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_rx
//  Description : Receiver for the MSB-first serial shift link. Samples the
//                line on bit-strobe cycles, detects a start bit (0), shifts
//                WIDTH data bits in at the LSB and checks the stop bit (1).
//                A good frame updates data_out with a one-cycle valid pulse;
//                a low stop bit gives a one-cycle frame_err pulse instead.
//
//  Parameters  : WIDTH      - data bits per frame (>= 2)
//
//  Ports       : clk        - system clock, all state changes on posedge
//                rst        - synchronous active-high reset
//                en         - bit strobe; line sampled only when en=1
//                sin        - serial line, idles high
//                data_out   - last correctly framed word (registered)
//                valid      - one-cycle pulse when data_out updates
//                frame_err  - one-cycle pulse on a low stop bit
//                parity_err - one-cycle pulse on even-parity failure
//                             (only with SERIAL_RX_PARITY_EN)
//                busy       - high while a frame is in progress
//
//  Build option: SERIAL_RX_PARITY_EN - adds an even-parity bit between the
//                data bits and the stop bit, plus the parity_err output.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             frame_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    // One extra count bit so the counter can hold WIDTH itself after the
    // last data sample; it is cleared again on the next start bit.
    localparam int               c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_STOP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_ferr;
`ifdef SERIAL_RX_PARITY_EN
    logic               r_par;
    logic               r_perr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses; they only get set on
            // the strobe that samples the stop bit.
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!sin) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                        end
                    end
                    S_DATA: begin
                        r_sr  <= {r_sr[WIDTH-2:0], sin};
                        r_cnt <= r_cnt + c_ONE;
                        if (r_cnt == c_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    S_PARITY: begin
                        r_par   <= sin;
                        r_state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        // A bad stop bit wins over any parity result.
                        if (!sin) begin
                            r_ferr <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        end else if (^{r_sr, r_par}) begin
                            r_perr <= 1'b1;
`endif
                        end else begin
                            r_data  <= r_sr;
                            r_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_ferr;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = r_perr;
`endif
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_rx
//  Description : Directed self-checking bench for serial_frame_rx (WIDTH=4).
//                Honours SERIAL_RX_PARITY_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    localparam int WIDTH = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int FL = WIDTH + 3;
`else
    localparam int FL = WIDTH + 2;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic             sin;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             frame_err;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_err;
`endif
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    serial_frame_rx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sin       (sin),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; after returning, outputs reflect
    // the rising edge that just sampled them.
    task automatic apply(input logic e, input logic s);
        en  = e;
        sin = s;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bits in send order (bit FL-1 first): start, data MSB..LSB,
    // [parity], stop.
    function automatic logic [FL-1:0] mk(input logic [3:0] d, input logic stop, input logic pbad);
`ifdef SERIAL_RX_PARITY_EN
        return {1'b0, d, (^d) ^ pbad, stop};
`else
        logic unused;
        unused = pbad;
        return {1'b0, d, stop};
`endif
    endfunction

    // Sends one frame with one strobe every 'per' cycles, checking pulses,
    // busy and data_out on every clock.
    task automatic frame(input string tag, input logic [FL-1:0] f, input int per,
                         input logic ev, input logic ef, input logic ep,
                         input logic [3:0] ed);
        for (int i = FL - 1; i >= 0; i--) begin
            for (int k = 0; k < per; k++) begin
                logic last;
                last = (i == 0) && (k == 0);
                apply(k == 0, f[i]);
                chk({tag, ".valid"}, 32'(valid),     32'(last ? ev : 1'b0));
                chk({tag, ".ferr"},  32'(frame_err), 32'(last ? ef : 1'b0));
`ifdef SERIAL_RX_PARITY_EN
                chk({tag, ".perr"},  32'(parity_err), 32'(last ? ep : 1'b0));
`else
                if (last && ep) chk({tag, ".perr_unsupported"}, 32'(valid), 32'(ev));
`endif
                chk({tag, ".busy"},  32'(busy), 32'(i != 0));
                if (i == 0) chk({tag, ".data"}, 32'(data_out), 32'(ed));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        sin = 1'b1;
        @(negedge clk);

        // 1: reset, then idle line with strobes
        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        chk("rst.data",  32'(data_out),  32'd0);
        chk("rst.valid", 32'(valid),     32'd0);
        chk("rst.ferr",  32'(frame_err), 32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            apply(1'b1, 1'b1);
            chk("idle.data",  32'(data_out),  32'd0);
            chk("idle.valid", 32'(valid),     32'd0);
            chk("idle.ferr",  32'(frame_err), 32'd0);
            chk("idle.busy",  32'(busy),      32'd0);
        end

        // 2: strobe every cycle
        frame("t2", mk(4'b1011, 1'b1, 1'b0), 1, 1'b1, 1'b0, 1'b0, 4'b1011);
        apply(1'b0, 1'b1);
        chk("t2.valid_after", 32'(valid), 32'd0);

        // 3: strobe every 3rd cycle, valid only one clock wide
        frame("t3", mk(4'b0110, 1'b1, 1'b0), 3, 1'b1, 1'b0, 1'b0, 4'b0110);

        // 4: bad stop bit keeps previous word
        frame("t4", mk(4'b1111, 1'b0, 1'b0), 1, 1'b0, 1'b1, 1'b0, 4'b0110);

        // 5: back-to-back frames, no idle gap
        frame("t5a", mk(4'b1001, 1'b1, 1'b0), 1, 1'b1, 1'b0, 1'b0, 4'b1001);
        frame("t5b", mk(4'b0111, 1'b1, 1'b0), 1, 1'b1, 1'b0, 1'b0, 4'b0111);

        // 6: reset after the 2nd data bit aborts the frame
        apply(1'b1, 1'b0);
        apply(1'b1, 1'b1);
        apply(1'b1, 1'b1);
        chk("t6.busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        apply(1'b1, 1'b0);
        rst = 1'b0;
        chk("t6.busy",  32'(busy),      32'd0);
        chk("t6.valid", 32'(valid),     32'd0);
        chk("t6.ferr",  32'(frame_err), 32'd0);
        chk("t6.data",  32'(data_out),  32'd0);
        apply(1'b0, 1'b1);
        chk("t6.quiet", 32'(valid | frame_err), 32'd0);
`ifdef SERIAL_RX_PARITY_EN
        frame("t6p", mk(4'b1100, 1'b1, 1'b1), 1, 1'b0, 1'b0, 1'b1, 4'b0000);
`endif
        frame("t6", mk(4'b1100, 1'b1, 1'b0), 1, 1'b1, 1'b0, 1'b0, 4'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
